// File: rtl/axi_rr_arbiter_if.sv
// rtl/axi_rr_arbiter_if.sv - master-side and downstream AXI3 signal bundle for axi_rr_arbiter
interface axi_rr_arbiter_if #(
    parameter int N_RD = 2,
    parameter int N_WR = 2
);
    // read masters (master i at slice i)
    logic [N_RD-1:0][31:0] m_araddr;
    logic [N_RD-1:0][7:0]  m_arlen;
    logic [N_RD-1:0]       m_arvalid;
    logic [N_RD-1:0]       m_arready;
    logic [N_RD-1:0]       m_rvalid;
    logic [N_RD-1:0]       m_rlast;
    logic [N_RD-1:0][31:0] m_rdata;
    logic [N_RD-1:0]       m_rready;

    // write masters (master i at slice i)
    logic [N_WR-1:0][31:0] m_awaddr;
    logic [N_WR-1:0][7:0]  m_awlen;
    logic [N_WR-1:0][2:0]  m_awsize;
    logic [N_WR-1:0]       m_awvalid;
    logic [N_WR-1:0][31:0] m_wdata;
    logic [N_WR-1:0][3:0]  m_wstrb;
    logic [N_WR-1:0]       m_wlast;
    logic [N_WR-1:0]       m_wvalid;
    logic [N_WR-1:0]       m_awready;
    logic [N_WR-1:0]       m_wready;
    logic [N_WR-1:0]       m_bvalid;
    logic [N_WR-1:0]       m_bready;

    // downstream AXI3 port
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;

    // arbiter side
    modport slave (
        input  m_araddr, m_arlen, m_arvalid, m_rready,
        input  m_awaddr, m_awlen, m_awsize, m_awvalid,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
        output m_arready, m_rvalid, m_rlast, m_rdata,
        output m_awready, m_wready, m_bvalid,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bvalid,
        output bready
    );

    // environment side (masters plus downstream slave)
    modport master (
        output m_araddr, m_arlen, m_arvalid, m_rready,
        output m_awaddr, m_awlen, m_awsize, m_awvalid,
        output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
        input  m_arready, m_rvalid, m_rlast, m_rdata,
        input  m_awready, m_wready, m_bvalid,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - N-to-1 AXI3 read/write arbiter; ARB_RR_EN selects round-robin over fixed priority
module axi_rr_arbiter #(
    parameter int N_RD = 2,
    parameter int N_WR = 2
) (
    input  logic            clk,
    input  logic            rst,
    axi_rr_arbiter_if.slave bus
);
    localparam int RD_IW = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int WR_IW = (N_WR > 1) ? $clog2(N_WR) : 1;

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    ar_state_t        r_ar_state;
    ar_state_t        w_ar_next;
    logic [RD_IW-1:0] r_ar_gnt;
    logic [RD_IW-1:0] w_ar_pick;
    logic             w_ar_hs;

    w_state_t         r_w_state;
    w_state_t         w_w_next;
    logic [WR_IW-1:0] r_w_gnt;
    logic [WR_IW-1:0] w_w_pick;
    logic             w_b_hs;

    logic             w_unused_bid;

`ifdef ARB_RR_EN
    // next index to favour; a winner moves it to the index just past itself
    logic [RD_IW-1:0] r_rd_ptr;
    logic [WR_IW-1:0] r_wr_ptr;
`endif

    assign w_unused_bid = ^bus.bid;

    assign w_ar_hs = (r_ar_state == AR_BUSY) && bus.arready;
    assign w_b_hs  = (r_w_state == W_RESP) && bus.bvalid && bus.m_bready[r_w_gnt];

    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.awburst = 2'b01;
    assign bus.m_rdata = {N_RD{bus.rdata}};

    // Read winner: lowest requester overall, overridden by the lowest at/after the pointer
    always_comb begin
        w_ar_pick = '0;
        for (int i = N_RD - 1; i >= 0; i--) begin
            if (bus.m_arvalid[i]) w_ar_pick = RD_IW'(i);
        end
`ifdef ARB_RR_EN
        for (int i = N_RD - 1; i >= 0; i--) begin
            if (bus.m_arvalid[i] && (RD_IW'(i) >= r_rd_ptr)) w_ar_pick = RD_IW'(i);
        end
`endif
    end

    // Write winner: same rule over the AW requests
    always_comb begin
        w_w_pick = '0;
        for (int i = N_WR - 1; i >= 0; i--) begin
            if (bus.m_awvalid[i]) w_w_pick = WR_IW'(i);
        end
`ifdef ARB_RR_EN
        for (int i = N_WR - 1; i >= 0; i--) begin
            if (bus.m_awvalid[i] && (WR_IW'(i) >= r_wr_ptr)) w_w_pick = WR_IW'(i);
        end
`endif
    end

    // Read FSM state, grant latch and pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar_state <= AR_IDLE;
            r_ar_gnt   <= '0;
`ifdef ARB_RR_EN
            r_rd_ptr   <= '0;
`endif
        end else begin
            r_ar_state <= w_ar_next;
            if ((r_ar_state == AR_IDLE) && (|bus.m_arvalid)) r_ar_gnt <= w_ar_pick;
`ifdef ARB_RR_EN
            if (w_ar_hs) r_rd_ptr <= (r_ar_gnt == RD_IW'(N_RD - 1)) ? '0 : r_ar_gnt + RD_IW'(1);
`endif
        end
    end

    // Read FSM next state and AR forwarding of the granted master
    always_comb begin
        w_ar_next     = r_ar_state;
        bus.arvalid   = 1'b0;
        bus.arid      = 4'(r_ar_gnt);
        bus.araddr    = bus.m_araddr[r_ar_gnt];
        bus.arlen     = bus.m_arlen[r_ar_gnt];
        bus.m_arready = '0;
        case (r_ar_state)
            AR_IDLE: begin
                if (|bus.m_arvalid) w_ar_next = AR_BUSY;
            end
            AR_BUSY: begin
                bus.arvalid = 1'b1;
                bus.m_arready[r_ar_gnt] = bus.arready;
                if (w_ar_hs) w_ar_next = AR_IDLE;
            end
            default: w_ar_next = AR_IDLE;
        endcase
    end

    // R routing by rid; ids with no master behind them are drained
    always_comb begin
        bus.rready   = 1'b1;
        bus.m_rvalid = '0;
        bus.m_rlast  = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (bus.rid == 4'(i)) begin
                bus.m_rvalid[i] = bus.rvalid;
                bus.m_rlast[i]  = bus.rlast;
                bus.rready      = bus.m_rready[i];
            end
        end
    end

    // Write FSM state, grant latch and pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_w_gnt   <= '0;
`ifdef ARB_RR_EN
            r_wr_ptr  <= '0;
`endif
        end else begin
            r_w_state <= w_w_next;
            if ((r_w_state == W_IDLE) && (|bus.m_awvalid)) r_w_gnt <= w_w_pick;
`ifdef ARB_RR_EN
            if (w_b_hs) r_wr_ptr <= (r_w_gnt == WR_IW'(N_WR - 1)) ? '0 : r_w_gnt + WR_IW'(1);
`endif
        end
    end

    // Write FSM next state; the grant owns AW, W and B until its response completes
    always_comb begin
        w_w_next      = r_w_state;
        bus.awvalid   = 1'b0;
        bus.awid      = 4'(r_w_gnt);
        bus.awaddr    = bus.m_awaddr[r_w_gnt];
        bus.awlen     = bus.m_awlen[r_w_gnt];
        bus.awsize    = bus.m_awsize[r_w_gnt];
        bus.wid       = 4'(r_w_gnt);
        bus.wdata     = bus.m_wdata[r_w_gnt];
        bus.wstrb     = bus.m_wstrb[r_w_gnt];
        bus.wlast     = bus.m_wlast[r_w_gnt];
        bus.wvalid    = 1'b0;
        bus.bready    = 1'b0;
        bus.m_awready = '0;
        bus.m_wready  = '0;
        bus.m_bvalid  = '0;
        case (r_w_state)
            W_IDLE: begin
                if (|bus.m_awvalid) w_w_next = W_ADDR;
            end
            W_ADDR: begin
                bus.awvalid = bus.m_awvalid[r_w_gnt];
                bus.m_awready[r_w_gnt] = bus.awready;
                if (bus.m_awvalid[r_w_gnt] && bus.awready) w_w_next = W_DATA;
            end
            W_DATA: begin
                bus.wvalid = bus.m_wvalid[r_w_gnt];
                bus.m_wready[r_w_gnt] = bus.wready;
                if (bus.m_wvalid[r_w_gnt] && bus.wready && bus.m_wlast[r_w_gnt]) w_w_next = W_RESP;
            end
            W_RESP: begin
                bus.bready = bus.m_bready[r_w_gnt];
                bus.m_bvalid[r_w_gnt] = bus.bvalid;
                if (w_b_hs) w_w_next = W_IDLE;
            end
            default: w_w_next = W_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb/tb_axi_rr_arbiter.sv - randomized scoreboard bench for axi_rr_arbiter
`timescale 1ns/1ps
module tb_axi_rr_arbiter;
    localparam int N_RD = 2;
    localparam int N_WR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rr_arbiter_if #(.N_RD(N_RD), .N_WR(N_WR)) bus ();
    axi_rr_arbiter #(.N_RD(N_RD), .N_WR(N_WR)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en   = 1'b0;
    bit slave_on = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        int              id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [3:0][31:0] data;
        logic [3:0][3:0]  strb;
    } w_exp_t;

    typedef struct {
        logic [N_RD-1:0] v;
        logic [N_RD-1:0] l;
        logic            rr;
        logic [31:0]     d;
    } r_exp_t;

    ar_exp_t ar_q[$];
    w_exp_t  w_q[$];
    r_exp_t  r_q[$];

    // reference arbitration: remember the last winner, search onward from it
    int rd_last = N_RD - 1;
    int wr_last = N_WR - 1;

    function automatic int pick(input int last, input logic [7:0] set, input int n);
`ifdef ARB_RR_EN
        for (int k = 1; k <= n; k++) begin
            if (set[(last + k) % n]) return (last + k) % n;
        end
`else
        for (int c = 0; c < n; c++) begin
            if (set[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // read masters: each round a random set requests and holds until served
    logic [31:0] rd_addr [N_RD];
    logic [7:0]  rd_len  [N_RD];

    task automatic read_rounds(input int n);
        for (int r = 0; r < n; r++) begin
            logic [7:0]      set;
            logic [7:0]      rem;
            logic [N_RD-1:0] served;
            int              w;
            int              cyc;
            set = 8'($urandom_range(1, (1 << N_RD) - 1));
            for (int i = 0; i < N_RD; i++) begin
                if (set[i]) begin
                    rd_addr[i] = $urandom;
                    rd_len[i]  = 8'($urandom);
                    bus.m_araddr[i]  = rd_addr[i];
                    bus.m_arlen[i]   = rd_len[i];
                    bus.m_arvalid[i] = 1'b1;
                end
            end
            rem = set;
            while (rem != 0) begin
                ar_exp_t e;
                w = pick(rd_last, rem, N_RD);
                e.id = w; e.addr = rd_addr[w]; e.len = rd_len[w];
                ar_q.push_back(e);
                rd_last = w;
                rem[w] = 1'b0;
            end
            cyc = 0;
            while ((|bus.m_arvalid) && cyc < 200) begin
                @(negedge clk);
                served = bus.m_arvalid & bus.m_arready;
                @(posedge clk); #1;
                bus.m_arvalid = bus.m_arvalid & ~served;
                cyc++;
            end
            if (cyc >= 200) begin
                timeout_fail("ar_round");
                bus.m_arvalid = '0;
            end
        end
    endtask

    // write masters: AW, then beats, then B
    logic [31:0]      wa_addr [N_WR];
    logic [7:0]       wa_len  [N_WR];
    logic [2:0]       wa_size [N_WR];
    logic [3:0][31:0] wd      [N_WR];
    logic [3:0][3:0]  ws      [N_WR];
    int               w_phase [N_WR];
    int               w_beat  [N_WR];

    task automatic write_rounds(input int n);
        for (int r = 0; r < n; r++) begin
            logic [7:0]      set;
            logic [7:0]      rem;
            logic [N_WR-1:0] aw_hs, w_hs, b_hs;
            int              w;
            int              cyc;
            bit              busy;
            set = 8'($urandom_range(1, (1 << N_WR) - 1));
            for (int i = 0; i < N_WR; i++) begin
                if (set[i]) begin
                    wa_addr[i] = $urandom;
                    wa_len[i]  = 8'($urandom_range(0, 3));
                    wa_size[i] = 3'($urandom_range(0, 2));
                    for (int b = 0; b < 4; b++) begin
                        wd[i][b] = $urandom;
                        ws[i][b] = 4'($urandom);
                    end
                    bus.m_awaddr[i]  = wa_addr[i];
                    bus.m_awlen[i]   = wa_len[i];
                    bus.m_awsize[i]  = wa_size[i];
                    bus.m_wdata[i]   = wd[i][0];
                    bus.m_wstrb[i]   = ws[i][0];
                    bus.m_wlast[i]   = (wa_len[i] == 0);
                    bus.m_wvalid[i]  = 1'b0;
                    bus.m_bready[i]  = 1'b0;
                    bus.m_awvalid[i] = 1'b1;
                    w_phase[i] = 1;
                    w_beat[i]  = 0;
                end
            end
            rem = set;
            while (rem != 0) begin
                w_exp_t e;
                w = pick(wr_last, rem, N_WR);
                e.id = w; e.addr = wa_addr[w]; e.len = wa_len[w]; e.size = wa_size[w];
                e.data = wd[w]; e.strb = ws[w];
                w_q.push_back(e);
                wr_last = w;
                rem[w] = 1'b0;
            end
            cyc  = 0;
            busy = 1'b1;
            while (busy && cyc < 400) begin
                @(negedge clk);
                aw_hs = bus.m_awvalid & bus.m_awready;
                w_hs  = bus.m_wvalid & bus.m_wready;
                b_hs  = bus.m_bready & bus.m_bvalid;
                @(posedge clk); #1;
                busy = 1'b0;
                for (int i = 0; i < N_WR; i++) begin
                    if (aw_hs[i]) begin
                        bus.m_awvalid[i] = 1'b0;
                        bus.m_wvalid[i]  = 1'b1;
                        w_phase[i] = 2;
                    end
                    if (w_hs[i]) begin
                        if (w_beat[i] == int'(wa_len[i])) begin
                            bus.m_wvalid[i] = 1'b0;
                            bus.m_bready[i] = 1'b1;
                            w_phase[i] = 3;
                        end else begin
                            w_beat[i]++;
                            bus.m_wdata[i] = wd[i][w_beat[i]];
                            bus.m_wstrb[i] = ws[i][w_beat[i]];
                            bus.m_wlast[i] = (w_beat[i] == int'(wa_len[i]));
                        end
                    end
                    if (b_hs[i]) begin
                        bus.m_bready[i] = 1'b0;
                        w_phase[i] = 0;
                    end
                    if (set[i] && w_phase[i] != 0) busy = 1'b1;
                end
                cyc++;
            end
            if (cyc >= 400) begin
                timeout_fail("w_round");
                bus.m_awvalid = '0;
                bus.m_wvalid  = '0;
                bus.m_bready  = '0;
            end
        end
    endtask

    // random R channel traffic, including ids with no master
    task automatic r_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            r_exp_t e;
            @(posedge clk); #1;
            if (k == 0) begin
                bus.rid = 4'd1; bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.m_rready = 2'b10;
            end else if (k == 1) begin
                bus.rid = 4'd5; bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.m_rready = 2'b00;
            end else begin
                bus.rid      = 4'($urandom_range(0, 7));
                bus.rvalid   = 1'($urandom);
                bus.rlast    = 1'($urandom);
                bus.m_rready = N_RD'($urandom);
            end
            bus.rdata = $urandom;
            e.v = '0; e.l = '0; e.rr = 1'b1; e.d = bus.rdata;
            if (int'(bus.rid) < N_RD) begin
                e.v[bus.rid] = bus.rvalid;
                e.l[bus.rid] = bus.rlast;
                e.rr = bus.m_rready[bus.rid];
            end
            r_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // downstream slave: random ready, B issued after each last beat
    initial begin
        logic last_hs, b_hs;
        forever begin
            @(negedge clk);
            last_hs = bus.wvalid & bus.wready & bus.wlast;
            b_hs    = bus.bvalid & bus.bready;
            @(posedge clk); #1;
            if (slave_on) begin
                bus.arready = ($urandom_range(0, 3) != 0);
                bus.awready = ($urandom_range(0, 3) != 0);
                bus.wready  = ($urandom_range(0, 3) != 0);
                if (b_hs) bus.bvalid = 1'b0;
                if (last_hs) begin
                    bus.bvalid = 1'b1;
                    bus.bid    = 4'($urandom);
                end
            end
        end
    end

    // AR monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && bus.arvalid && bus.arready) begin
                if (ar_q.size() == 0) begin
                    timeout_fail("ar_unexpected");
                end else begin
                    ar_exp_t e;
                    e = ar_q.pop_front();
                    check("arid", bus.arid, 64'(e.id));
                    check("araddr", bus.araddr, e.addr);
                    check("arlen", bus.arlen, e.len);
                    check("m_arready", bus.m_arready, 64'(1 << e.id));
                    check("arsize_arburst", {bus.arsize, bus.arburst}, 5'b010_01);
                end
            end
        end
    end

    // AW / W / B monitor
    initial begin
        int beat = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (bus.awvalid && bus.awready) begin
                    if (w_q.size() == 0) timeout_fail("aw_unexpected");
                    else begin
                        check("awid", bus.awid, 64'(w_q[0].id));
                        check("awaddr", bus.awaddr, w_q[0].addr);
                        check("awlen", bus.awlen, w_q[0].len);
                        check("awsize", bus.awsize, w_q[0].size);
                        check("awburst", bus.awburst, 2'b01);
                        check("m_awready", bus.m_awready, 64'(1 << w_q[0].id));
                    end
                end
                if (bus.wvalid && bus.wready) begin
                    if (w_q.size() == 0) timeout_fail("w_unexpected");
                    else begin
                        check("wid", bus.wid, 64'(w_q[0].id));
                        check("wdata", bus.wdata, w_q[0].data[beat]);
                        check("wstrb", bus.wstrb, w_q[0].strb[beat]);
                        check("wlast", bus.wlast, 64'(beat == int'(w_q[0].len)));
                        check("m_wready", bus.m_wready, 64'(1 << w_q[0].id));
                        beat++;
                    end
                end
                if (bus.bvalid && bus.bready) begin
                    if (w_q.size() == 0) timeout_fail("b_unexpected");
                    else begin
                        check("m_bvalid", bus.m_bvalid, 64'(1 << w_q[0].id));
                        void'(w_q.pop_front());
                        beat = 0;
                    end
                end
            end
        end
    end

    // R monitor
    initial begin
        forever begin
            @(negedge clk);
            if (r_q.size() != 0) begin
                r_exp_t e;
                e = r_q.pop_front();
                check("m_rvalid", bus.m_rvalid, e.v);
                check("m_rlast", bus.m_rlast, e.l);
                check("rready", bus.rready, e.rr);
                check("m_rdata", bus.m_rdata[N_RD-1], e.d);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, bus.arvalid, 1'b0);
        check({tag, "_awvalid"}, bus.awvalid, 1'b0);
        check({tag, "_wvalid"}, bus.wvalid, 1'b0);
        check({tag, "_bready"}, bus.bready, 1'b0);
        check({tag, "_m_arready"}, bus.m_arready, 0);
        check({tag, "_m_awready"}, bus.m_awready, 0);
        check({tag, "_m_wready"}, bus.m_wready, 0);
        check({tag, "_m_bvalid"}, bus.m_bvalid, 0);
    endtask

    // reset during the third data beat of a master-1 burst
    task automatic reset_mid_burst();
        int cyc;
        int beats;
        logic hs;
        @(posedge clk); #1;
        slave_on = 1'b0;
        mon_en   = 1'b0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b0; bus.arready = 1'b0;
        bus.m_awaddr[1] = 32'h1000_0040; bus.m_awlen[1] = 8'd3; bus.m_awsize[1] = 3'd2;
        bus.m_wdata[1] = 32'hA5A5_0000; bus.m_wstrb[1] = 4'hF; bus.m_wlast[1] = 1'b0;
        bus.m_awvalid[1] = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = bus.m_awvalid[1] & bus.m_awready[1];
            @(posedge clk); #1;
            cyc++;
        end
        if (!hs) timeout_fail("rst_aw");
        bus.m_awvalid[1] = 1'b0;
        bus.m_wvalid[1]  = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 20) begin
            @(negedge clk);
            if (bus.m_wvalid[1] & bus.m_wready[1]) beats++;
            @(posedge clk); #1;
            bus.m_wdata[1] = bus.m_wdata[1] + 1;
            cyc++;
        end
        if (beats < 2) timeout_fail("rst_beats");
        check("pre_rst_wvalid", bus.wvalid, 1'b1);
        check("pre_rst_wid", bus.wid, 4'd1);
        #2 rst = 1'b1;
        #1 check_quiet("mid_rst");
        check("mid_rst_rready", bus.rready, (bus.rid < 4'(N_RD)) ? bus.m_rready[bus.rid] : 1'b1);
        bus.m_wvalid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.awready = 1'b0;
        bus.m_awvalid = 2'b11;
        bus.m_araddr[0] = 32'h2000; bus.m_araddr[1] = 32'h3000;
        bus.m_arvalid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_awvalid", bus.awvalid, 1'b1);
        check("post_rst_awid", bus.awid, 4'd0);
        check("post_rst_arid", bus.arid, 4'd0);
        check("post_rst_araddr", bus.araddr, 32'h2000);
        @(posedge clk); #1;
        bus.awready = 1'b1;
        @(negedge clk);
        check("post_rst_m_awready", bus.m_awready, 2'b01);
        @(posedge clk); #1;
        bus.m_awvalid = '0;
        bus.m_arvalid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_araddr = '0; bus.m_arlen = '0; bus.m_arvalid = '0; bus.m_rready = '0;
        bus.m_awaddr = '0; bus.m_awlen = '0; bus.m_awsize = '0; bus.m_awvalid = '0;
        bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_wlast = '0; bus.m_wvalid = '0; bus.m_bready = '0;
        bus.arready = 1'b0; bus.rid = 4'd5; bus.rdata = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bid = '0; bus.bvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.m_arvalid = 2'b11; bus.m_awvalid = 2'b11; bus.arready = 1'b1; bus.awready = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        check("reset_rready_drain", bus.rready, 1'b1);
        check("reset_m_rvalid", bus.m_rvalid, 0);
        @(posedge clk); #1;
        bus.m_arvalid = '0; bus.m_awvalid = '0;
        rst = 1'b0;
        mon_en   = 1'b1;
        slave_on = 1'b1;
        fork
            read_rounds(30);
            write_rounds(30);
            r_traffic(300);
        join
        repeat (4) @(posedge clk);
        check("ar_queue_drained", ar_q.size(), 0);
        check("w_queue_drained", w_q.size(), 0);
        reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
